alu_mc: RTL and testbench

- Multi-cycle, parametrised execute unit that succeeds the single-cycle combinational ALU.
- Keeps the 10 base RV integer operations with their existing encodings.
- Adds the RV M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), computed iteratively.
- Sits in the execute stage behind a valid/ready handshake so the pipeline stalls on long operations. Result and zero flag are registered.

---
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV integer/M-extension execute unit behind a valid/ready handshake.
// Base ops finish in one cycle; multiply and divide iterate one bit per cycle on magnitudes.
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op,
  output logic            zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state_q, state_d;
  logic [XLEN-1:0] op_q, op_d, m_q, m_d, res, base_r, spec_r, abs_a, abs_b, mul_r, div_r;
  logic [2*XLEN:0] p_q, p_d, mul_p, div_p;
  logic [2*XLEN-1:0] sprod;
  logic [XLEN:0] mul_sum, sh, diff;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic zero_q, zero_d, neg_q, neg_d, rneg_q, rneg_d, wr;
  logic a_s, b_s, is_mul, is_div, by0, ovf;
  assign a_s    = a[XLEN-1] && (alu_ctrl == 5'd11 || alu_ctrl == 5'd12 || alu_ctrl == 5'd14 || alu_ctrl == 5'd16);
  assign b_s    = b[XLEN-1] && (alu_ctrl == 5'd11 || alu_ctrl == 5'd14 || alu_ctrl == 5'd16);
  assign abs_a  = a_s ? -a : a;
  assign abs_b  = b_s ? -b : b;
  assign is_mul = alu_ctrl >= 5'd10 && alu_ctrl <= 5'd13;
  assign is_div = alu_ctrl >= 5'd14 && alu_ctrl <= 5'd17;
  assign by0    = is_div && b == '0;
  assign ovf    = (alu_ctrl == 5'd14 || alu_ctrl == 5'd16) && a == MIN && b == '1;
  assign spec_r = by0 ? ((alu_ctrl == 5'd14 || alu_ctrl == 5'd15) ? '1 : a) : (alu_ctrl == 5'd14 ? a : '0);
  always_comb begin
    base_r = '0;
    case (alu_ctrl)
      5'd0: base_r = a + b;
      5'd1: base_r = a - b;
      5'd2: base_r = a << b[SHW-1:0];
      5'd3: base_r = XLEN'($signed(a) < $signed(b));
      5'd4: base_r = XLEN'(a < b);
      5'd5: base_r = a ^ b;
      5'd6: base_r = a >> b[SHW-1:0];
      5'd7: base_r = $signed(a) >>> b[SHW-1:0];
      5'd8: base_r = a | b;
      5'd9: base_r = a & b;
      default: base_r = '0;
    endcase
  end
  // shift-add: multiplier sits in the low half and is consumed LSB first
  assign mul_sum = p_q[2*XLEN:XLEN] + {1'b0, p_q[0] ? m_q : '0};
  assign mul_p   = {1'b0, mul_sum, p_q[XLEN-1:1]};
  assign sprod   = neg_q ? -mul_p[2*XLEN-1:0] : mul_p[2*XLEN-1:0];
  assign mul_r   = ctrl_q == 5'd10 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
  // restoring step: remainder in the high half, dividend/quotient shifting through the low half
  assign sh      = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign diff    = sh - {1'b0, m_q};
  assign div_p   = diff[XLEN] ? {sh, p_q[XLEN-2:0], 1'b0} : {diff, p_q[XLEN-2:0], 1'b1};
  assign div_r   = (ctrl_q == 5'd14 || ctrl_q == 5'd15) ? (neg_q ? -div_p[XLEN-1:0] : div_p[XLEN-1:0])
                                                        : (rneg_q ? -div_p[2*XLEN-1:XLEN] : div_p[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    wr      = 1'b0;
    res     = op_q;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (in_valid) begin
        ctrl_d = alu_ctrl;
        neg_d  = a_s ^ b_s;
        rneg_d = a_s;
        cnt_d  = SHW'(XLEN - 1);
        if (is_mul) begin
          state_d = MUL;
          p_d     = {{(XLEN+1){1'b0}}, abs_b};
          m_d     = abs_a;
        end else if (is_div && !by0 && !ovf) begin
          state_d = DIV;
          p_d     = {{(XLEN+1){1'b0}}, abs_a};
          m_d     = abs_b;
        end else begin
          state_d = DONE;
          wr      = 1'b1;
          res     = is_div ? spec_r : base_r;
        end
      end
      MUL: begin
        p_d   = mul_p;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          wr      = 1'b1;
          res     = mul_r;
        end
      end
      DIV: begin
        p_d   = div_p;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          wr      = 1'b1;
          res     = div_r;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign op_d   = wr ? res : op_q;
  assign zero_d = wr ? res == '0 : zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      zero_q  <= 1'b1;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign op        = op_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized bench for alu_mc against a latency/result model built from RV arithmetic rules.
module tb_alu_mc;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, zero;
  logic [31:0] a = 0, b = 0, op;
  logic [4:0]  alu_ctrl = 0;
  int          errors = 0, checks = 0;
  bit          cmp_en = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .zero(zero)
  );

  function automatic logic [31:0] ref_res(logic [4:0] c, logic [31:0] x, logic [31:0] y);
    int sx = x, sy = y;
    longint ps;
    logic [63:0] pu = {32'b0, x} * {32'b0, y};
    bit ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    logic [31:0] r = 0;
    case (c)
      0: r = x + y;
      1: r = x - y;
      2: r = x << y[4:0];
      3: r = (sx < sy) ? 1 : 0;
      4: r = (x < y) ? 1 : 0;
      5: r = x ^ y;
      6: r = x >> y[4:0];
      7: r = sx >>> y[4:0];
      8: r = x | y;
      9: r = x & y;
      10: r = pu[31:0];
      11: begin ps = longint'(sx) * longint'(sy); r = ps[63:32]; end
      12: begin ps = longint'(sx) * longint'({32'b0, y}); r = ps[63:32]; end
      13: r = pu[63:32];
      14: if (y == 0) r = '1; else if (ov) r = x; else r = sx / sy;
      15: if (y == 0) r = '1; else r = x / y;
      16: if (y == 0) r = x; else if (ov) r = 0; else r = sx % sy;
      17: if (y == 0) r = x; else r = x % y;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(logic [4:0] c, logic [31:0] x, logic [31:0] y);
    bit ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF) && (c == 14 || c == 16);
    if (c >= 10 && c <= 13) return 33;
    if (c >= 14 && c <= 17 && y != 0 && !ov) return 33;
    return 1;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // model: a countdown to completion plus a held result
  int          m_busy;
  logic        m_valid, m_zero;
  logic [31:0] m_op, m_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_valid <= 0; m_op <= 0; m_zero <= 1; m_pend <= 0;
    end else if (flush) begin
      m_busy <= 0; m_valid <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1; m_op <= m_pend; m_zero <= (m_pend == 0);
      end
    end else if (in_valid) begin
      if (ref_lat(alu_ctrl, a, b) == 1) begin
        m_valid <= 1;
        m_op    <= ref_res(alu_ctrl, a, b);
        m_zero  <= (ref_res(alu_ctrl, a, b) == 0);
      end else begin
        m_busy <= ref_lat(alu_ctrl, a, b) - 1;
        m_pend <= ref_res(alu_ctrl, a, b);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("handshake", {62'b0, in_ready, out_valid}, {62'b0, (!m_valid && m_busy == 0), m_valid});
      chk("result", {31'b0, zero, op}, {31'b0, m_zero, m_op});
    end
  end

  task automatic issue(logic [4:0] c, logic [31:0] x, logic [31:0] y);
    for (int i = 0; i < 100 && !in_ready; i++) begin @(posedge clk); #1; end
    alu_ctrl = c; a = x; b = y; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run(string name, logic [4:0] c, logic [31:0] x, logic [31:0] y, logic [31:0] exp, int exp_lat);
    int lat = 1;
    issue(c, x, y);
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " op"}, op, exp);
    chk({name, " zero"}, zero, exp == 0);
    chk({name, " model"}, ref_res(c, x, y), exp);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    logic [31:0] prev;
    bit rose;
    repeat (2) @(posedge clk);
    #1;
    chk("reset op", op, 0);
    chk("reset zero", zero, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    rst_n = 1;
    cmp_en = 1;

    run("ADD",    0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
    run("SUB",    1,  32'd5,         32'd5,         32'h0,         1);
    run("SRA",    7,  32'h8000_0000, 32'h21,        32'hC000_0000, 1);
    run("SLTU",   4,  32'h1,         32'hFFFF_FFFF, 32'h1,         1);
    run("MULH",   11, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33);
    run("MULHU",  13, 32'hFFFF_FFFF, 32'h2,         32'h1,         33);
    run("MUL",    10, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 33);
    run("MULHSU", 12, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33);
    run("DIV",    14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
    run("REM",    16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33);
    run("DIVU0",  15, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1);
    run("REM0",   17, 32'h1234,      32'h0,         32'h1234,      1);
    run("REMOVF", 16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    run("DIVOVF", 14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("ILLEGAL",20, 32'h55,        32'h66,        32'h0,         1);

    issue(0, 32'd3, 32'd4);
    for (int i = 0; i < 100 && !out_valid; i++) begin @(posedge clk); #1; end
    alu_ctrl = 1; a = 32'd9; b = 32'd1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold op", op, 32'd7);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;

    prev = op;
    issue(15, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1; in_valid = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    chk("flush op kept", op, prev);
    rose = 0;
    repeat (40) begin @(posedge clk); #1; rose |= out_valid; end
    chk("flush no result", rose, 0);

    issue(10, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst op", op, 0);
    chk("rst zero", zero, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r = $urandom % 8;
      in_valid  = ($urandom % 2) == 1;
      alu_ctrl  = 5'($urandom % 32);
      a         = $urandom;
      b         = $urandom;
      if (r == 0) b = 0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 60) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (40) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
